// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-lane data memory: size codes, FSM states and lane helpers.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Low address bits with the misaligned part cleared; size 11 behaves as word.
    function automatic logic [1:0] align_offset(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return off;
            SZ_HALF: return {off[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        logic [1:0] a;
        a = align_offset(size, off);
        case (size)
            SZ_BYTE: return 4'b0001 << a;
            SZ_HALF: return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bytelane_if.sv
// MEM-stage request/response bundle for dmem_bytelane; err exists only with DMEM_ERR_EN.
interface dmem_bytelane_if;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
`ifdef DMEM_ERR_EN
    logic        err;

    modport master (output req, we, size, uns, addr, wdata, input busy, done, rdata, err);
    modport slave  (input req, we, size, uns, addr, wdata, output busy, done, rdata, err);
`else
    modport master (output req, we, size, uns, addr, wdata, input busy, done, rdata);
    modport slave  (input req, we, size, uns, addr, wdata, output busy, done, rdata);
`endif
endinterface

// File: rtl/dmem_load_align.sv
// Load lane select with sign/zero extension; offset is expected already aligned to size.
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_uns,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[8*i_offset +: 8];
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
        case (i_size)
            SZ_BYTE: o_data = {{24{~i_uns & w_byte[7]}}, w_byte};
            SZ_HALF: o_data = {{16{~i_uns & w_half[15]}}, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule

// File: rtl/dmem_bytelane.sv
// Byte-lane data memory with registered response and WAIT_CYCLES wait states.
// Define DMEM_ERR_EN to add the err output and reject misaligned/peripheral accesses.
//
// state | meaning
// IDLE  | no access outstanding
// WAIT  | access accepted, counting down wait states (busy=1)
// RESP  | done pulse; store committed on entry, rdata valid; may accept next access
module dmem_bytelane
    import dmem_pkg::*;
#(
    parameter int         DEPTH         = 256,
    parameter int         ADDR_BITS     = 8,
    parameter int         WAIT_CYCLES   = 0,
    parameter logic [3:0] PERIPH_NIBBLE = 4'h4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_bytelane_if.slave bus
);

    localparam logic [3:0] CNT_LOAD  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);
    localparam state_t     ACC_STATE = (WAIT_CYCLES == 0) ? RESP : WAIT;

    state_t      r_state, w_state_nx;
    logic [3:0]  r_cnt;
    logic        r_we, r_uns;
    logic [1:0]  r_size;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [31:0] r_mem [DEPTH];

    logic                 w_busy, w_done, w_accept, w_commit, w_wr, w_block, w_misal, w_periph;
    logic                 w_we, w_uns;
    logic [1:0]           w_size, w_off;
    logic [3:0]           w_lanes;
    logic [31:0]          w_addr, w_wdata, w_wdata_rep, w_load;
    logic [ADDR_BITS-1:0] w_idx;
    logic                 w_unused;

    // Zero wait states commit on the acceptance edge itself, so use the live bus fields.
    assign w_we    = (WAIT_CYCLES == 0) ? bus.we    : r_we;
    assign w_uns   = (WAIT_CYCLES == 0) ? bus.uns   : r_uns;
    assign w_size  = (WAIT_CYCLES == 0) ? bus.size  : r_size;
    assign w_addr  = (WAIT_CYCLES == 0) ? bus.addr  : r_addr;
    assign w_wdata = (WAIT_CYCLES == 0) ? bus.wdata : r_wdata;

    assign w_accept = bus.req & ~w_busy;
    assign w_off    = align_offset(w_size, w_addr[1:0]);
    assign w_lanes  = lane_mask(w_size, w_addr[1:0]);
    assign w_idx    = w_addr[ADDR_BITS+1:2];
    assign w_periph = (w_addr[31:28] == PERIPH_NIBBLE);
`ifdef DMEM_ERR_EN
    assign w_misal  = misaligned(w_size, w_addr[1:0]);
`else
    assign w_misal  = 1'b0;
`endif
    assign w_block  = w_periph | w_misal;
    assign w_commit = reset & (w_state_nx == RESP);
    assign w_wr     = w_commit & w_we & ~w_block;
    assign w_unused = ^{w_addr[27:ADDR_BITS+2]};

    always_comb begin
        case (w_size)
            SZ_BYTE: w_wdata_rep = {4{w_wdata[7:0]}};
            SZ_HALF: w_wdata_rep = {2{w_wdata[15:0]}};
            default: w_wdata_rep = w_wdata;
        endcase
    end

    dmem_load_align u_load_align (
        .i_word   (r_mem[w_idx]),
        .i_offset (w_off),
        .i_size   (w_size),
        .i_uns    (w_uns),
        .o_data   (w_load)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nx = ACC_STATE;
            WAIT:    if (r_cnt == 4'd0) w_state_nx = RESP;
            RESP:    w_state_nx = w_accept ? ACC_STATE : IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == WAIT);
        w_done = (r_state == RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 4'd0;
            r_we    <= 1'b0;
            r_uns   <= 1'b0;
            r_size  <= SZ_WORD;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we    <= bus.we;
                r_uns   <= bus.uns;
                r_size  <= bus.size;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            if (w_accept && ACC_STATE == WAIT) r_cnt <= CNT_LOAD;
            else if (r_state == WAIT && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                 r_rdata <= 32'd0;
        else if (w_commit && !w_we) r_rdata <= w_block ? 32'd0 : w_load;
    end

    // RAM is deliberately not reset so contents survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (w_lanes[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
            end
        end
    end

    assign bus.busy  = w_busy;
    assign bus.done  = w_done;
    assign bus.rdata = r_rdata;

`ifdef DMEM_ERR_EN
    logic r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        r_err <= 1'b0;
        else if (w_commit) r_err <= w_block;
    end

    assign bus.err = w_done & r_err;
`endif

endmodule

// File: tb/tb_dmem_bytelane.sv
// Directed bench for dmem_bytelane: one instance with no wait states, one with WAIT_CYCLES=3.
module tb_dmem_bytelane;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    dmem_bytelane_if bus0 ();
    dmem_bytelane_if bus3 ();

    dmem_bytelane #(.WAIT_CYCLES(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_bytelane #(.WAIT_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] tb_rd;
    int          tb_lat;
    logic        tb_er;
    logic [7:0]  ob, od;
    logic [31:0] rd_a, rd_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input logic rq, input logic w, input logic [1:0] sz,
                         input logic u, input logic [31:0] a, input logic [31:0] wd);
        if (d == 0) begin
            bus0.req = rq; bus0.we = w; bus0.size = sz; bus0.uns = u; bus0.addr = a; bus0.wdata = wd;
        end else begin
            bus3.req = rq; bus3.we = w; bus3.size = sz; bus3.uns = u; bus3.addr = a; bus3.wdata = wd;
        end
    endtask

    function automatic logic get_done(input int d);
        return (d == 0) ? bus0.done : bus3.done;
    endfunction

    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? bus0.rdata : bus3.rdata;
    endfunction

    task automatic access(input int d, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat, output logic er);
        @(negedge clk);
        drive(d, 1'b1, w, sz, u, a, wd);
        @(posedge clk);
        #1;
        drive(d, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'd0);
        lat = 1;
        while (!get_done(d) && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rd = get_rdata(d);
`ifdef DMEM_ERR_EN
        er = (d == 0) ? bus0.err : bus3.err;
`else
        er = 1'b0;
`endif
    endtask

    task automatic st(input int d, input string tag, input logic [1:0] sz,
                      input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] rd;
        int          lat;
        logic        er;
        access(d, 1'b1, sz, 1'b0, a, wd, rd, lat, er);
        check({tag, "_lat"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
    endtask

    task automatic ld(input int d, input string tag, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        int          lat;
        logic        er;
        access(d, 1'b0, sz, u, a, 32'd0, rd, lat, er);
        check({tag, "_lat"}, 32'(lat), (d == 0) ? 32'd1 : 32'd4);
        check(tag, rd, exp);
    endtask

    initial begin
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'd0);
        drive(3, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'd0);
        #12;
        check("rst_busy0", bus0.busy, 1'b0);
        check("rst_done0", bus0.done, 1'b0);
        check("rst_rdata0", bus0.rdata, 32'd0);
        check("rst_busy3", bus3.busy, 1'b0);
        check("rst_done3", bus3.done, 1'b0);
        @(negedge clk);
        reset = 1'b1;

        st(0, "p1_st", SZ_WORD, 32'h10, 32'hDEADBEEF);
        ld(0, "p1_ld", SZ_WORD, 1'b0, 32'h10, 32'hDEADBEEF);

        st(0, "p2_stw", SZ_WORD, 32'h20, 32'h11223344);
        st(0, "p2_stb", SZ_BYTE, 32'h22, 32'h123456AA);
        ld(0, "p2_ldw", SZ_WORD, 1'b0, 32'h20, 32'h11AA3344);
        ld(0, "p2_ldb_s", SZ_BYTE, 1'b0, 32'h22, 32'hFFFFFFAA);
        ld(0, "p2_ldb_u", SZ_BYTE, 1'b1, 32'h22, 32'h000000AA);
        ld(0, "p2_ldb_l1", SZ_BYTE, 1'b0, 32'h21, 32'h00000033);

        st(0, "p3_stw", SZ_WORD, 32'h24, 32'h55667788);
        st(0, "p3_sth", SZ_HALF, 32'h26, 32'hABCD8001);
        ld(0, "p3_ldh_s", SZ_HALF, 1'b0, 32'h26, 32'hFFFF8001);
        ld(0, "p3_ldh_u", SZ_HALF, 1'b1, 32'h26, 32'h00008001);
        ld(0, "p3_ldw", SZ_WORD, 1'b0, 32'h24, 32'h80017788);
        ld(0, "p3_ldh_lo", SZ_HALF, 1'b0, 32'h24, 32'h00007788);
        ld(0, "p3_ldb_hi", SZ_BYTE, 1'b0, 32'h27, 32'hFFFFFF80);
        ld(0, "sz11_ld", 2'b11, 1'b0, 32'h10, 32'hDEADBEEF);

        st(0, "p5_st0", SZ_WORD, 32'h0, 32'h12345678);
        st(0, "p5_stp", SZ_WORD, 32'h40000000, 32'h00000005);
        ld(0, "p5_ld0", SZ_WORD, 1'b0, 32'h0, 32'h12345678);
        ld(0, "p5_ldp", SZ_WORD, 1'b0, 32'h40000000, 32'h0);
        ld(0, "p5_ldp10", SZ_WORD, 1'b0, 32'h40000010, 32'h0);
        st(0, "p5_stwrap", SZ_WORD, 32'h400, 32'hCAFEF00D);
        ld(0, "p5_ldwrap", SZ_WORD, 1'b0, 32'h0, 32'hCAFEF00D);
        ld(0, "p5_alias_hi", SZ_WORD, 1'b0, 32'h10000010, 32'hDEADBEEF);

        st(0, "mis_st30", SZ_WORD, 32'h30, 32'h0BADF00D);
`ifdef DMEM_ERR_EN
        access(0, 1'b0, SZ_WORD, 1'b0, 32'h12, 32'd0, tb_rd, tb_lat, tb_er);
        check("mis_ldw_data", tb_rd, 32'd0);
        check("mis_ldw_err", tb_er, 1'b1);
        access(0, 1'b1, SZ_WORD, 1'b0, 32'h31, 32'hFFFFFFFF, tb_rd, tb_lat, tb_er);
        check("mis_stw_err", tb_er, 1'b1);
        check("mis_stw_lat", 32'(tb_lat), 32'd1);
        ld(0, "mis_ld30", SZ_WORD, 1'b0, 32'h30, 32'h0BADF00D);
        access(0, 1'b1, SZ_WORD, 1'b0, 32'h40000000, 32'h5, tb_rd, tb_lat, tb_er);
        check("per_err", tb_er, 1'b1);
        access(0, 1'b0, SZ_WORD, 1'b0, 32'h30, 32'd0, tb_rd, tb_lat, tb_er);
        check("ok_err", tb_er, 1'b0);
`else
        ld(0, "mis_ldw", SZ_WORD, 1'b0, 32'h12, 32'hDEADBEEF);
        ld(0, "mis_ldh", SZ_HALF, 1'b1, 32'h23, 32'h000011AA);
        st(0, "mis_st31", SZ_WORD, 32'h31, 32'hFFFFFFFF);
        ld(0, "mis_ld30", SZ_WORD, 1'b0, 32'h30, 32'hFFFFFFFF);
`endif

        st(3, "p4_st8", SZ_WORD, 32'h8, 32'hA5A5A5A5);
        st(3, "p4_stc", SZ_WORD, 32'hC, 32'h13579BDF);
        ld(3, "p4_ld8", SZ_WORD, 1'b0, 32'h8, 32'hA5A5A5A5);

        // Two loads with req held: busy 3 cycles, done 4th, second accepted on the done cycle.
        @(negedge clk);
        drive(3, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h8, 32'd0);
        ob = 8'd0;
        od = 8'd0;
        rd_a = 32'd0;
        rd_b = 32'd0;
        @(posedge clk);
        for (int s = 0; s < 8; s++) begin
            #1;
            ob[s] = bus3.busy;
            od[s] = bus3.done;
            if (s == 3) begin
                rd_a = bus3.rdata;
                drive(3, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'hC, 32'd0);
            end
            if (s == 4) drive(3, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'd0);
            if (s == 7) rd_b = bus3.rdata;
            @(posedge clk);
        end
        check("p4_busy_pat", ob, 8'h77);
        check("p4_done_pat", od, 8'h88);
        check("p4_rd_a", rd_a, 32'hA5A5A5A5);
        check("p4_rd_b", rd_b, 32'h13579BDF);

        @(negedge clk);
        drive(3, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h8, 32'h77777777);
        @(posedge clk);
        #1;
        drive(3, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'd0, 32'd0);
        check("rw_busy_pre", bus3.busy, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rw_busy", bus3.busy, 1'b0);
        check("rw_done", bus3.done, 1'b0);
        check("rw_rdata3", bus3.rdata, 32'd0);
        check("rw_rdata0", bus0.rdata, 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        ld(3, "rw_nocommit", SZ_WORD, 1'b0, 32'h8, 32'hA5A5A5A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
